ghash_seq_ctrl: RTL
===================

Name: ghash_seq_ctrl

Overview:
- Frame sequencer that drives the N-block-per-cycle GHASH datapath for AES-GCM.
- Accepts AAD beats, then ciphertext beats, from upstream. Generates the datapath start-of-packet, valid and per-block skip controls.
- Zero-pads partial final blocks and counts AAD and ciphertext lengths in bits.
- Appends the len(A)||len(C) block, waits for the datapath result and presents the final GHASH value with a one-cycle valid pulse to the tag stage.

Parameters:
- NB_BLOCK, 128, block width in bits; only 128 is legal.
- N_BLOCKS, 2, blocks per beat.
- LOG2_N_BLOCKS, 1, clog2(N_BLOCKS).
- NB_LEN, 64, width of each bit-length counter.
- GHASH_LATENCY, 1, cycles from the datapath valid beat carrying the length block to a stable datapath o_data_y.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_sof  in  1  first beat of a frame; qualified by a valid.
- i_aad_valid  in  1  beat carries AAD blocks.
- i_txt_valid  in  1  beat carries ciphertext blocks.
- i_last  in  1  last beat of the current section (AAD or text).
- i_no_txt  in  1  sampled with the last AAD beat; frame has no ciphertext.
- i_block_en  in  N_BLOCKS  valid blocks in the beat; contiguous from bit 0.
- i_nbytes_last  in  5  valid bytes in the highest enabled block of an i_last beat; range 1..16.
- i_data_bus  in  N_BLOCKS*NB_BLOCK  block ii at [ii*NB_BLOCK +: NB_BLOCK]; byte 0 at the MSBs.
- o_ready  out  1  upstream may present a beat.
- o_gh_data_bus  out  N_BLOCKS*NB_BLOCK  to datapath i_data_x_bus.
- o_gh_skip_bus  out  N_BLOCKS  to datapath i_skip_bus.
- o_gh_sop  out  1  to datapath i_sop.
- o_gh_valid  out  1  to datapath i_valid.
- i_gh_data_y  in  NB_BLOCK  from datapath o_data_y.
- o_hash  out  NB_BLOCK  final GHASH of the frame.
- o_hash_valid  out  1  one-cycle pulse.
- o_error  out  1  sticky protocol error (optional feature).

Behaviour:
- Clock and reset: one clock, i_clock. Reset is synchronous and active-high on i_reset.
- Reset values:
  - FSM returns to IDLE; o_ready=1.
  - o_gh_valid=0, o_gh_sop=0, o_gh_skip_bus=all ones, o_gh_data_bus=0.
  - o_hash=0, o_hash_valid=0, o_error=0; length counters cleared.
- Reset mid-frame aborts the frame: no o_hash_valid for it.
- Beat acceptance: acc = o_ready & (i_aad_valid|i_txt_valid).
  - All datapath outputs are registered, so there is 1 cycle from acc to o_gh_valid.
  - o_gh_skip_bus = ~i_block_en, registered.
  - A beat with i_block_en=0 is accepted and forwarded with all skips set; no length change.
- FSM states IDLE, AAD, TXT, LEN, WAIT, OUT:
  - IDLE: acc&i_sof → AAD if i_aad_valid, else TXT. Beats without i_sof are dropped.
  - AAD: accepts i_aad_valid beats. acc&i_last → TXT, or → LEN if i_no_txt=1.
  - TXT: accepts i_txt_valid beats. acc&i_last → LEN.
  - LEN: o_ready=0. Issue one beat: block0 = {len_aad[63:0], len_txt[63:0]}, other blocks skipped. Then → WAIT.
  - WAIT: o_ready=0. Count GHASH_LATENCY cycles, then → OUT.
  - OUT: o_hash ← i_gh_data_y; o_hash_valid=1 for one cycle; → IDLE. o_ready=0 here; o_ready=1 again in IDLE.
- A frame starting directly in TXT has len_aad=0. An AAD-only frame has len_txt=0.
- o_gh_sop is asserted with the first forwarded beat of a frame, coincident with o_gh_valid.
- Lengths:
  - Each enabled full block adds 128 to its section counter.
  - The highest enabled block of an i_last beat adds 8*i_nbytes_last, and bytes nbytes..15 are forced to 0 (bits [127-8*nbytes:0]).
  - Counters saturate at all ones.
- i_sof in AAD or TXT restarts the frame: counters cleared, o_gh_sop reasserted. i_sof in LEN, WAIT or OUT cannot occur because o_ready=0 there.
- i_aad_valid and i_txt_valid both high: treated as a text beat if the state is TXT, otherwise as an AAD beat.
- An AAD beat arriving in TXT is dropped and counts as a protocol error.

Optional Feature:
- Macro GHASH_SEQ_ERR_CHK_EN.
- Defined: o_error is set and sticky until i_reset or the next i_sof on any of:
  - non-contiguous i_block_en;
  - i_nbytes_last of 0 or greater than 16 on an i_last beat;
  - a section beat in the wrong state;
  - counter saturation.
  Data flow is unchanged.
- Undefined: o_error is tied to 0 and no checking logic is built.

Test Plan:
- Frame of 1 AAD beat (2 full blocks), i_last, i_no_txt=1 → LEN beat block0 = {64'd256, 64'd0}, skip=2'b10; o_hash_valid 1+GHASH_LATENCY+1 cycles after the LEN beat, o_hash = i_gh_data_y.
- 1 AAD beat with en=2'b01, nbytes=4; 1 TXT beat with en=2'b11, nbytes=16 → AAD block bytes 4..15 = 0; len block {64'd32, 64'd256}; o_gh_sop only on the first beat.
- TXT-only frame, i_sof with i_txt_valid, en=2'b11, nbytes=1, last → len block {64'd0, 64'd136}.
- i_sof reissued mid-TXT → counters restart; the next LEN block reflects only the new frame; exactly one o_hash_valid.
- i_reset asserted during WAIT → next cycle o_ready=1, o_gh_valid=0, no o_hash_valid pulse.
- With GHASH_SEQ_ERR_CHK_EN: en=2'b10 → o_error=1 and held; cleared by the next i_sof.

Source files
------------

// File: rtl/ghash_seq_ctrl.sv
// ghash_seq_ctrl: sequences AAD then ciphertext beats into the N-block GHASH datapath, zero-pads the final partial block, counts section lengths in bits, appends len(A)||len(C) and returns the hash. Optional protocol checking is built only with GHASH_SEQ_ERR_CHK_EN defined.
// Latency: 1 cycle from an accepted beat to o_gh_valid; o_hash_valid pulses GHASH_LATENCY+2 cycles after the LEN state is entered.
// Backpressure: o_ready is low from LEN through OUT and high again in IDLE; the datapath is never stalled and o_ready does not depend on it.
module ghash_seq_ctrl #(
    parameter int NB_BLOCK      = 128,
    parameter int N_BLOCKS      = 2,
    parameter int LOG2_N_BLOCKS = 1,
    parameter int NB_LEN        = 64,
    parameter int GHASH_LATENCY = 1
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_sof,
    input  logic                         i_aad_valid,
    input  logic                         i_txt_valid,
    input  logic                         i_last,
    input  logic                         i_no_txt,
    input  logic [N_BLOCKS-1:0]          i_block_en,
    input  logic [4:0]                   i_nbytes_last,
    input  logic [N_BLOCKS*NB_BLOCK-1:0] i_data_bus,
    output logic                         o_ready,
    output logic [N_BLOCKS*NB_BLOCK-1:0] o_gh_data_bus,
    output logic [N_BLOCKS-1:0]          o_gh_skip_bus,
    output logic                         o_gh_sop,
    output logic                         o_gh_valid,
    input  logic [NB_BLOCK-1:0]          i_gh_data_y,
    output logic [NB_BLOCK-1:0]          o_hash,
    output logic                         o_hash_valid,
    output logic                         o_error
);

    localparam int NB_BUS    = N_BLOCKS * NB_BLOCK;
    localparam int BLK_SHIFT = $clog2(NB_BLOCK);
    localparam int NB_WAIT   = (GHASH_LATENCY > 1) ? $clog2(GHASH_LATENCY) : 1;
    localparam int NB_IDX    = LOG2_N_BLOCKS + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AAD,
        ST_TXT,
        ST_LEN,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [NB_BUS-1:0]     gh_data_q, gh_data_d;
    logic [N_BLOCKS-1:0]   gh_skip_q, gh_skip_d;
    logic                  gh_sop_q, gh_sop_d;
    logic                  gh_valid_q, gh_valid_d;
    logic [NB_LEN-1:0]     len_aad_q, len_aad_d;
    logic [NB_LEN-1:0]     len_txt_q, len_txt_d;
    logic [NB_WAIT-1:0]    wait_cnt_q, wait_cnt_d;
    logic [NB_BLOCK-1:0]   hash_q, hash_d;
    logic                  hash_valid_q, hash_valid_d;

    logic                  acc;
    logic                  beat_txt;
    logic                  in_sec;
    logic                  fwd;
    logic [NB_IDX-1:0]     n_en;
    logic [NB_IDX-1:0]     hi_idx;
    logic [NB_BLOCK-1:0]   byte_mask;
    logic [NB_BUS-1:0]     data_pad;
    logic [NB_LEN:0]       add_bits;
    logic [NB_LEN:0]       sum_bits;
    logic [NB_LEN-1:0]     base_aad;
    logic [NB_LEN-1:0]     base_txt;
    logic [NB_LEN-1:0]     sat_bits;

    // Classify the presented beat, pad its last block and compute its bit-length contribution
    always_comb begin
        acc = ready_q & (i_aad_valid | i_txt_valid);
        // Both valids high count as text only while already in the text section
        beat_txt = i_txt_valid & ((state_q == ST_TXT) | ~i_aad_valid);
        in_sec   = ((state_q == ST_AAD) & ~beat_txt) | ((state_q == ST_TXT) & beat_txt);
        // i_sof (re)starts a frame from any accepting state; otherwise the beat must match the section
        fwd      = acc & (i_sof | in_sec);

        n_en   = '0;
        hi_idx = '0;
        for (int ii = 0; ii < N_BLOCKS; ii++) begin
            if (i_block_en[ii]) begin
                n_en   = n_en + 1'b1;
                hi_idx = NB_IDX'(ii);
            end
        end

        // Keep bytes 0..nbytes-1 (byte 0 sits at the MSBs)
        if (i_nbytes_last >= 5'd16) begin
            byte_mask = '1;
        end else begin
            byte_mask = ~({NB_BLOCK{1'b1}} >> {i_nbytes_last, 3'b000});
        end

        data_pad = i_data_bus;
        for (int ii = 0; ii < N_BLOCKS; ii++) begin
            if (i_last && (n_en != '0) && (hi_idx == NB_IDX'(ii))) begin
                data_pad[ii*NB_BLOCK +: NB_BLOCK] = i_data_bus[ii*NB_BLOCK +: NB_BLOCK] & byte_mask;
            end
        end

        if (n_en == '0) begin
            add_bits = '0;
        end else if (i_last) begin
            add_bits = ((NB_LEN+1)'(n_en - 1'b1) << BLK_SHIFT) + ((NB_LEN+1)'(i_nbytes_last) << 3);
        end else begin
            add_bits = (NB_LEN+1)'(n_en) << BLK_SHIFT;
        end

        base_aad = i_sof ? '0 : len_aad_q;
        base_txt = i_sof ? '0 : len_txt_q;
        sum_bits = (NB_LEN+1)'(beat_txt ? base_txt : base_aad) + add_bits;
        sat_bits = sum_bits[NB_LEN] ? '1 : sum_bits[NB_LEN-1:0];
    end

    // Frame sequencer next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        gh_data_d    = gh_data_q;
        gh_skip_d    = gh_skip_q;
        gh_sop_d     = 1'b0;
        gh_valid_d   = 1'b0;
        len_aad_d    = len_aad_q;
        len_txt_d    = len_txt_q;
        wait_cnt_d   = wait_cnt_q;
        hash_d       = hash_q;
        hash_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_AAD, ST_TXT: begin
                if (fwd) begin
                    gh_valid_d = 1'b1;
                    gh_sop_d   = i_sof;
                    gh_data_d  = data_pad;
                    gh_skip_d  = ~i_block_en;
                    if (beat_txt) begin
                        len_aad_d = base_aad;
                        len_txt_d = sat_bits;
                    end else begin
                        len_aad_d = sat_bits;
                        len_txt_d = base_txt;
                    end
                    if (i_last) begin
                        state_d = (beat_txt | i_no_txt) ? ST_LEN : ST_TXT;
                    end else begin
                        state_d = beat_txt ? ST_TXT : ST_AAD;
                    end
                end
            end
            ST_LEN: begin
                gh_valid_d                = 1'b1;
                gh_data_d                 = '0;
                gh_data_d[NB_BLOCK-1:0]   = {len_aad_q, len_txt_q};
                gh_skip_d                 = '1;
                gh_skip_d[0]              = 1'b0;
                wait_cnt_d                = '0;
                state_d                   = ST_WAIT;
            end
            ST_WAIT: begin
                if (int'(wait_cnt_q) >= GHASH_LATENCY - 1) begin
                    state_d = ST_OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                hash_d       = i_gh_data_y;
                hash_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_AAD) || (state_d == ST_TXT);
    end

    // State and registered outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            gh_data_q    <= '0;
            gh_skip_q    <= '1;
            gh_sop_q     <= 1'b0;
            gh_valid_q   <= 1'b0;
            len_aad_q    <= '0;
            len_txt_q    <= '0;
            wait_cnt_q   <= '0;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            gh_data_q    <= gh_data_d;
            gh_skip_q    <= gh_skip_d;
            gh_sop_q     <= gh_sop_d;
            gh_valid_q   <= gh_valid_d;
            len_aad_q    <= len_aad_d;
            len_txt_q    <= len_txt_d;
            wait_cnt_q   <= wait_cnt_d;
            hash_q       <= hash_d;
            hash_valid_q <= hash_valid_d;
        end
    end

`ifdef GHASH_SEQ_ERR_CHK_EN
    logic err_q, err_d;
    logic bad_en, bad_nb, bad_state, sat_hit;

    // Sticky protocol error, cleared by the next accepted start of frame
    always_comb begin
        bad_en    = acc & (|(i_block_en & (i_block_en + 1'b1)));
        bad_nb    = acc & i_last & ((i_nbytes_last == 5'd0) | (i_nbytes_last > 5'd16));
        bad_state = acc & ~fwd;
        sat_hit   = fwd & sum_bits[NB_LEN];
        err_d     = err_q;
        if (acc & i_sof) begin
            err_d = 1'b0;
        end
        if (bad_en | bad_nb | bad_state | sat_hit) begin
            err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_error = err_q;
`else
    assign o_error = 1'b0;
`endif

    assign o_ready       = ready_q;
    assign o_gh_data_bus = gh_data_q;
    assign o_gh_skip_bus = gh_skip_q;
    assign o_gh_sop      = gh_sop_q;
    assign o_gh_valid    = gh_valid_q;
    assign o_hash        = hash_q;
    assign o_hash_valid  = hash_valid_q;

endmodule
